col_drain_scheduler: RTL and testbench

Round-robin scheduler that drains the per-column output FIFO array (ReLU'd 8-bit results) into the single shared output FIFO. It issues one-hot read enables and muxes the returned word. It tags each word with its column index and tracks per-tile element counts. It pulses tile-done once every column has delivered ROW words. It replaces the free-running column data controller with a backpressure-aware, tile-framed sequencer.

---
 rtl/col_drain_scheduler_pkg.sv | 10 +
 rtl/col_drain_scheduler_if.sv | 26 ++
 rtl/col_drain_scheduler_rr_arbiter.sv | 20 ++
 rtl/col_drain_scheduler.sv | 116 +++++++++++
 tb/tb_col_drain_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/col_drain_scheduler_pkg.sv
// col_drain_scheduler_pkg: shared state encoding and width helpers for the column drain scheduler
package col_drain_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/col_drain_scheduler_if.sv
// col_drain_scheduler_if: column FIFO array and shared output FIFO signals of the drain scheduler
interface col_drain_scheduler_if #(
  parameter int COL = 3,
  parameter int W_DATA = 8,
  parameter int W_IDX = col_drain_scheduler_pkg::idx_w(COL)
);
  logic [COL-1:0] i_fifo_empty;
  logic [COL*W_DATA-1:0] i_data;
  logic [COL-1:0] i_data_valid;
  logic i_out_full;
  logic [COL-1:0] o_read_enable;
  logic [W_DATA-1:0] o_data;
  logic [W_IDX-1:0] o_col_idx;
  logic o_wren;
  logic o_tile_done;
  logic o_busy;
  logic o_err;
  modport master (
    output i_fifo_empty, i_data, i_data_valid, i_out_full,
    input o_read_enable, o_data, o_col_idx, o_wren, o_tile_done, o_busy, o_err
  );
  modport slave (
    input i_fifo_empty, i_data, i_data_valid, i_out_full,
    output o_read_enable, o_data, o_col_idx, o_wren, o_tile_done, o_busy, o_err
  );
endinterface

// File: rtl/col_drain_scheduler_rr_arbiter.sv
// col_drain_scheduler_rr_arbiter: combinational round-robin pick starting at ptr, with next pointer
module col_drain_scheduler_rr_arbiter #(
  parameter int COL = 3,
  parameter int W_IDX = 2
) (
  input  logic [COL-1:0] req,
  input  logic [W_IDX-1:0] ptr,
  output logic [COL-1:0] gnt,
  output logic [W_IDX-1:0] idx,
  output logic [W_IDX-1:0] nxt
);
  // lowest requester at or above ptr wins, otherwise the lowest requester overall (wrap)
  always_comb begin
    idx = '0;
    for (int c = COL - 1; c >= 0; c--) if (req[c]) idx = W_IDX'(c);
    for (int c = COL - 1; c >= 0; c--) if (req[c] && W_IDX'(c) >= ptr) idx = W_IDX'(c);
    gnt = (|req) ? COL'(1) << idx : '0;
    nxt = (idx == W_IDX'(COL - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/col_drain_scheduler.sv
// col_drain_scheduler: tile-framed round-robin drain of column FIFOs into the shared output FIFO
module col_drain_scheduler
  import col_drain_scheduler_pkg::*;
#(
  parameter int COL = 3,
  parameter int ROW = 9,
  parameter int W_DATA = 8,
  parameter int W_IDX = idx_w(COL),
  parameter int W_CNT = cnt_w(ROW)
) (
  input logic i_clk,
  input logic i_rst,
  col_drain_scheduler_if.slave bus
);
  state_e state_q, state_d;
  logic [W_IDX-1:0] ptr_q, ptr_d, gnt_q, gnt_d, col_idx_q, col_idx_d, arb_idx, arb_nxt;
  logic [COL-1:0][W_CNT-1:0] cnt_q, cnt_d;
  logic [COL-1:0][W_DATA-1:0] col_data;
  logic [COL-1:0] rden_q, rden_d, req, sat, arb_gnt;
  logic [W_DATA-1:0] data_q, data_d;
  logic wren_q, wren_d, done_q, done_d, busy_q, busy_d, err_q, err_d;
  assign col_data = bus.i_data;
  // a column may be read only while it has data and has not yet delivered its full tile
  always_comb begin
    for (int c = 0; c < COL; c++) begin
      sat[c] = cnt_q[c] == W_CNT'(ROW);
      req[c] = !bus.i_fifo_empty[c] && !sat[c];
    end
  end
  col_drain_scheduler_rr_arbiter #(.COL(COL), .W_IDX(W_IDX)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .nxt(arb_nxt)
  );
  // sequencer next state: one read in flight at most, full only sampled between reads
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    rden_d = '0;
    data_d = data_q;
    col_idx_d = col_idx_q;
    wren_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (!bus.i_out_full && |req) begin
          state_d = ISSUE;
          gnt_d = arb_idx;
          ptr_d = arb_nxt;
          rden_d = arb_gnt;
        end else if (&sat) begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d[gnt_q] = cnt_q[gnt_q] + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        err_d = err_q | (|(bus.i_data_valid & ~(COL'(1) << gnt_q)));
        if (bus.i_data_valid[gnt_q]) begin
          data_d = col_data[gnt_q];
          col_idx_d = gnt_q;
          wren_d = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      rden_q <= '0;
      data_q <= '0;
      col_idx_q <= '0;
      wren_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      rden_q <= rden_d;
      data_q <= data_d;
      col_idx_q <= col_idx_d;
      wren_q <= wren_d;
      done_q <= done_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign bus.o_read_enable = rden_q;
  assign bus.o_data = data_q;
  assign bus.o_col_idx = col_idx_q;
  assign bus.o_wren = wren_q;
  assign bus.o_tile_done = done_q;
  assign bus.o_busy = busy_q;
  assign bus.o_err = err_q;
endmodule

// File: tb/tb_col_drain_scheduler.sv
// tb_col_drain_scheduler: directed vectors and corner-case sequences for col_drain_scheduler
module tb_col_drain_scheduler;
  localparam int COL = 3;
  localparam int ROW = 9;
  localparam int W_DATA = 8;
  localparam int W_IDX = 2;
  typedef struct {
    logic [COL-1:0] empty;
    logic [W_DATA-1:0] d;
    logic [COL-1:0] rden;
    logic [W_IDX-1:0] col;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [COL-1:0] pend = '0;
  logic resp_en = 1'b1;
  int bad_col = -1;
  logic [W_DATA-1:0] resp_data = '0;
  vec_t vt[8];
  always #5 clk = ~clk;
  col_drain_scheduler_if #(.COL(COL), .W_DATA(W_DATA), .W_IDX(W_IDX)) bus ();
  col_drain_scheduler #(.COL(COL), .ROW(ROW), .W_DATA(W_DATA)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // one clock: column FIFO model answers a read enable seen last cycle with valid+data this cycle
  task automatic tick();
    logic [COL-1:0][W_DATA-1:0] lanes;
    logic [COL-1:0] v;
    int tgt;
    @(negedge clk);
    cyc++;
    v = '0;
    for (int c = 0; c < COL; c++) lanes[c] = ~resp_data;
    if (resp_en && pend != '0) begin
      tgt = bad_col;
      if (tgt < 0) for (int c = 0; c < COL; c++) if (pend[c]) tgt = c;
      for (int c = 0; c < COL; c++) if (c == tgt) begin
        v[c] = 1'b1;
        lanes[c] = resp_data;
      end
    end
    bus.i_data_valid = v;
    bus.i_data = lanes;
    pend = bus.o_read_enable;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.i_fifo_empty = '1;
    bus.i_out_full = 1'b0;
    resp_en = 1'b1;
    bad_col = -1;
    tick();
    tick();
    rst = 1'b0;
    pend = '0;
  endtask
  task automatic wait_rden(output logic [COL-1:0] r);
    r = '0;
    for (int n = 0; n < 30 && r == '0; n++) begin
      tick();
      r = bus.o_read_enable;
    end
  endtask
  task automatic wait_wren(output logic w);
    w = 1'b0;
    for (int n = 0; n < 30 && !w; n++) begin
      tick();
      w = bus.o_wren;
    end
  endtask
  task automatic chk_idle_outputs(input string nm);
    chk({nm, " rden"}, 32'(bus.o_read_enable), 0);
    chk({nm, " data"}, 32'(bus.o_data), 0);
    chk({nm, " col_idx"}, 32'(bus.o_col_idx), 0);
    chk({nm, " wren"}, 32'(bus.o_wren), 0);
    chk({nm, " tile_done"}, 32'(bus.o_tile_done), 0);
    chk({nm, " busy"}, 32'(bus.o_busy), 0);
    chk({nm, " err"}, 32'(bus.o_err), 0);
  endtask
  initial begin
    logic [COL-1:0] r;
    logic w;
    int wcnt, dcnt, last, dcyc;
    bus.i_fifo_empty = '1;
    bus.i_out_full = 1'b0;
    bus.i_data = '0;
    bus.i_data_valid = '0;
    vt[0] = '{3'b101, 8'h5A, 3'b010, 2'd1};
    vt[1] = '{3'b000, 8'hC3, 3'b100, 2'd2};
    vt[2] = '{3'b000, 8'h11, 3'b001, 2'd0};
    vt[3] = '{3'b110, 8'h22, 3'b001, 2'd0};
    vt[4] = '{3'b010, 8'h33, 3'b100, 2'd2};
    vt[5] = '{3'b011, 8'h44, 3'b100, 2'd2};
    vt[6] = '{3'b000, 8'h55, 3'b001, 2'd0};
    vt[7] = '{3'b000, 8'h66, 3'b010, 2'd1};
    do_reset();
    chk_idle_outputs("reset");
    for (int i = 0; i < 8; i++) begin
      bus.i_fifo_empty = vt[i].empty;
      resp_data = vt[i].d;
      wait_rden(r);
      chk($sformatf("vec%0d rden", i), 32'(r), 32'(vt[i].rden));
      chk($sformatf("vec%0d busy", i), 32'(bus.o_busy), 1);
      bus.i_fifo_empty = '1;
      wait_wren(w);
      chk($sformatf("vec%0d wren", i), 32'(w), 1);
      chk($sformatf("vec%0d data", i), 32'(bus.o_data), 32'(vt[i].d));
      chk($sformatf("vec%0d col", i), 32'(bus.o_col_idx), 32'(vt[i].col));
    end
    do_reset();
    bus.i_fifo_empty = '0;
    resp_data = 8'hA7;
    wcnt = 0;
    dcnt = 0;
    last = 0;
    dcyc = 0;
    for (int n = 0; n < 130; n++) begin
      tick();
      if (bus.o_wren) begin
        chk("rr order", 32'(bus.o_col_idx), 32'(wcnt % 3));
        wcnt++;
        last = cyc;
        if (wcnt == COL * ROW) bus.i_fifo_empty = '1;
      end
      if (bus.o_tile_done) begin
        dcnt++;
        dcyc = cyc;
        chk("done busy", 32'(bus.o_busy), 1);
      end
    end
    chk("rr writes", 32'(wcnt), 27);
    chk("rr done pulses", 32'(dcnt), 1);
    chk("rr done timing", 32'(dcyc), 32'(last + 1));
    bus.i_fifo_empty = 3'b110;
    resp_data = 8'h99;
    wait_rden(r);
    chk("cnt cleared rden", 32'(r), 3'b001);
    bus.i_fifo_empty = '1;
    wait_wren(w);
    chk("cnt cleared data", 32'(bus.o_data), 8'h99);
    do_reset();
    bus.i_out_full = 1'b1;
    bus.i_fifo_empty = '0;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("full no rden", 32'(bus.o_read_enable), 0);
    end
    bus.i_out_full = 1'b0;
    resp_data = 8'h3C;
    wait_rden(r);
    chk("full drop rden", 32'(r), 3'b001);
    bus.i_out_full = 1'b1;
    wait_wren(w);
    chk("inflight wren", 32'(w), 1);
    chk("inflight data", 32'(bus.o_data), 8'h3C);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("full held no rden", 32'(bus.o_read_enable), 0);
    end
    bus.i_out_full = 1'b0;
    wait_rden(r);
    chk("full release rden", 32'(r), 3'b010);
    bus.i_fifo_empty = '1;
    wait_wren(w);
    do_reset();
    bus.i_fifo_empty = 3'b110;
    wcnt = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (bus.o_wren) begin
        chk("sat col0 src", 32'(bus.o_col_idx), 0);
        wcnt++;
      end
    end
    chk("sat col0 words", 32'(wcnt), 9);
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("sat no rden", 32'(bus.o_read_enable), 0);
      chk("sat no done", 32'(bus.o_tile_done), 0);
    end
    bus.i_fifo_empty = '0;
    wcnt = 0;
    dcnt = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (bus.o_wren) begin
        chk("sat skip col0", 32'(bus.o_col_idx != 0), 1);
        wcnt++;
        if (wcnt == 2 * ROW) bus.i_fifo_empty = '1;
      end
      if (bus.o_tile_done) dcnt++;
    end
    chk("sat rest words", 32'(wcnt), 18);
    chk("sat done pulses", 32'(dcnt), 1);
    do_reset();
    bus.i_fifo_empty = 3'b110;
    bad_col = 2;
    wait_rden(r);
    chk("err rden", 32'(r), 3'b001);
    bus.i_fifo_empty = '1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("err no wren", 32'(bus.o_wren), 0);
    end
    chk("err set", 32'(bus.o_err), 1);
    bad_col = -1;
    for (int n = 0; n < 3; n++) tick();
    chk("err sticky", 32'(bus.o_err), 1);
    do_reset();
    bus.i_fifo_empty = '0;
    resp_en = 1'b0;
    wait_rden(r);
    chk("midrst rden", 32'(r), 3'b001);
    bus.i_fifo_empty = '1;
    tick();
    chk("midrst in wait", 32'(bus.o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_data_valid = 3'b001;
    bus.i_data = {COL{8'h77}};
    tick();
    tick();
    chk_idle_outputs("midrst");
    bus.i_fifo_empty = '0;
    resp_en = 1'b1;
    wait_rden(r);
    chk("midrst ptr", 32'(r), 3'b001);
    bus.i_fifo_empty = '1;
    wait_wren(w);
    chk("midrst err clear", 32'(bus.o_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
